// File: rtl/prv32_id_ex_stage.sv
// prv32_id_ex_stage: ID/EX pipeline register with forwarding, load-use detection and flush
module prv32_id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [4:0]        id_alufn,
    input  logic              id_asel_pc,
    input  logic              id_bsel_imm,
    input  logic              id_sh_imm,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regwrite,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regwrite,
    input  logic [XLEN-1:0]   memwb_result,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [XLEN-1:0]   alu_shamt,
    output logic [4:0]        alu_alufn,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              load_use_stall
);
    logic              v;
    logic [XLEN-1:0]   pc, rs1_data, rs2_data, imm;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [4:0]        alufn;
    logic              asel_pc, bsel_imm, sh_imm, regwrite, memread, memwrite;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;
    logic              accept;
    always_comb begin
        fwd_rs1 = (rs1 != '0 && exmem_regwrite && exmem_rd == rs1) ? exmem_result :
                  (rs1 != '0 && memwb_regwrite && memwb_rd == rs1) ? memwb_result : rs1_data;
        fwd_rs2 = (rs2 != '0 && exmem_regwrite && exmem_rd == rs2) ? exmem_result :
                  (rs2 != '0 && memwb_regwrite && memwb_rd == rs2) ? memwb_result : rs2_data;
        load_use_stall = v & memread & (rd != '0) & in_valid & ((id_rs1 == rd) | (id_rs2 == rd));
        in_ready = (~v | ex_ready) & ~load_use_stall;
        accept = in_valid & in_ready & ~flush;
        ex_valid = v;
        alu_a = asel_pc ? pc : fwd_rs1;
        alu_b = bsel_imm ? imm : fwd_rs2;
        alu_shamt = {{(XLEN-5){1'b0}}, sh_imm ? imm[4:0] : fwd_rs2[4:0]};
        alu_alufn = alufn;
        ex_store_data = fwd_rs2;
        ex_pc = pc;
        ex_rd = rd;
        ex_regwrite = v & regwrite;
        ex_memread = v & memread;
        ex_memwrite = v & memwrite;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            pc <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            imm <= '0;
            rs1 <= '0;
            rs2 <= '0;
            rd <= '0;
            alufn <= '0;
            asel_pc <= 1'b0;
            bsel_imm <= 1'b0;
            sh_imm <= 1'b0;
            regwrite <= 1'b0;
            memread <= 1'b0;
            memwrite <= 1'b0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (accept) begin
            v <= 1'b1;
            pc <= id_pc;
            rs1_data <= id_rs1_data;
            rs2_data <= id_rs2_data;
            imm <= id_imm;
            rs1 <= id_rs1;
            rs2 <= id_rs2;
            rd <= id_rd;
            alufn <= id_alufn;
            asel_pc <= id_asel_pc;
            bsel_imm <= id_bsel_imm;
            sh_imm <= id_sh_imm;
            regwrite <= id_regwrite;
            memread <= id_memread;
            memwrite <= id_memwrite;
        end else if (v && ex_ready) begin
            v <= 1'b0;
        end else if (v) begin
            rs1_data <= fwd_rs1;
            rs2_data <= fwd_rs2;
        end
    end
endmodule

// File: doc/prv32_id_ex_stage.md
Name: prv32_id_ex_stage

Overview:
- ID/EX pipeline register for the prv32 core; sits directly upstream of the EX-stage ALU and drives its a, b, shamt and alufn inputs.
- Captures decoded operands from ID under a valid/ready handshake, applies EX/MEM and MEM/WB forwarding, detects load-use hazards and supports flush on branch/jump redirect.
- One-entry skid-free stage; all outputs to the ALU are registered state plus forwarding muxes.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  ID holds a decoded instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  kill the instruction held in EX and any instruction being accepted
- id_pc  in  32  instruction PC
- id_rs1_data, id_rs2_data  in  32  register-file reads
- id_imm  in  32  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_alufn  in  5  ALU function code
- id_asel_pc  in  1  1: ALU a = pc (AUIPC/JAL)
- id_bsel_imm  in  1  1: ALU b = imm
- id_sh_imm  in  1  1: shamt = imm[4:0], else rs2[4:0]
- id_regwrite, id_memread, id_memwrite  in  1  control
- exmem_rd  in  5;  exmem_regwrite  in  1;  exmem_result  in  32  EX/MEM forward source
- memwb_rd  in  5;  memwb_regwrite  in  1;  memwb_result  in  32  MEM/WB forward source
- ex_ready  in  1  downstream accepts EX instruction
- ex_valid  out  1  EX holds a live instruction
- alu_a, alu_b  out  32  ALU operands
- alu_shamt  out  32  zero-extended 5-bit shift amount
- alu_alufn  out  5
- ex_store_data  out  32  forwarded rs2 for stores
- ex_pc  out  32;  ex_rd  out  5;  ex_regwrite, ex_memread, ex_memwrite  out  1
- load_use_stall  out  1  hazard indicator to fetch/decode

Behaviour:
- Reset: ex_valid=0, every registered field (pc, data, imm, indices, alufn, selects, controls) = 0. Consequently alu_a=alu_b=alu_shamt=0, alu_alufn=0, ex_regwrite=ex_memread=ex_memwrite=0.
- load_use_stall = ex_valid & ex_memread & (ex_rd!=0) & in_valid & ((id_rs1==ex_rd) | (id_rs2==ex_rd)). Matching is on indices only (no use-flags).
- in_ready = (~ex_valid | ex_ready) & ~load_use_stall.
- Accept: in_valid & in_ready -> all id_* captured, ex_valid=1 next cycle. Latency is 1 cycle.
- Drain without refill: ex_valid & ex_ready & ~accept -> ex_valid=0 (bubble); the register fields keep their values.
- Load-use case: EX drains, a bubble is inserted and ID holds. The instruction is accepted on the first cycle the hazard clears.
- Hold: ex_valid & ~ex_ready -> fields hold, except rs1_data/rs2_data, which are overwritten each held cycle with their forwarded values. This prevents loss of a MEM/WB result that retires during the stall.
- Flush has priority over accept and hold: ex_valid=0 next cycle, nothing captured. The controls ex_regwrite/ex_memread/ex_memwrite are gated by ex_valid at the outputs.
- Forwarding, per operand, combinational. Source index 0 is never forwarded.
  - If exmem_regwrite & exmem_rd==rs -> exmem_result.
  - Else if memwb_regwrite & memwb_rd==rs -> memwb_result.
  - Else registered data.
  - EX/MEM takes priority when both match.
- alu_a = asel_pc ? pc : fwd_rs1.
- alu_b = bsel_imm ? imm : fwd_rs2.
- ex_store_data = fwd_rs2 (always, independent of bsel).
- alu_shamt = {27'b0, sh_imm ? imm[4:0] : fwd_rs2[4:0]}.
- Simultaneous rst and flush/accept: rst wins.
- Simultaneous drain and accept: the new instruction replaces the old; ex_valid stays 1.

Test Plan:
- Reset, then in_valid=1, id_rs1_data=5, id_rs2_data=7, alufn=0 -> next cycle ex_valid=1, alu_a=5, alu_b=7, in_ready=1.
- EX/MEM and MEM/WB both write x3 (0xAAAA, 0x5555); EX rs1=x3 -> alu_a=0xAAAA. Repeat with rs1=x0 and exmem_rd=0 -> registered value, no forward.
- EX holds a load to x4 (ex_memread=1); ID in_valid with id_rs2=4 -> load_use_stall=1, in_ready=0. With ex_ready=1, the next cycle shows ex_valid=0; the cycle after, the instruction is accepted.
- ex_ready=0 for 3 cycles; MEM/WB presents rd=x6=0x1234 only in cycle 1, EX rs2=x6 -> after the stall, alu_b=0x1234.
- flush=1 together with in_valid=1 -> next cycle ex_valid=0, ex_regwrite=0. rst asserted mid-hold -> all outputs 0 next cycle.
- id_sh_imm=1, imm=0xFFFFFFE3 -> alu_shamt=3. id_sh_imm=0, rs2=0x25 -> alu_shamt=5. id_asel_pc=1, pc=0x100 -> alu_a=0x100.
